// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation is in flight at a time: IDLE (accept) -> EXEC (capture ALU
// result) -> RESP (hold result until the owning requester consumes it).
module alu_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_in1,
    input  logic [XLEN-1:0] req0_in2,
    input  logic [2:0]      req0_funct3,
    input  logic            req0_funct7,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [XLEN-1:0] rsp0_data,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_in1,
    input  logic [XLEN-1:0] req1_in2,
    input  logic [2:0]      req1_funct3,
    input  logic            req1_funct7,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp1_data,

    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    output logic [2:0]      alu_funct3,
    output logic            alu_funct7,
    input  logic [XLEN-1:0] alu_out,

    output logic            busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]      state_q,      state_d;
    logic            last_grant_q, last_grant_d;
    logic            owner_q,      owner_d;
    logic [XLEN-1:0] in1_q,        in1_d;
    logic [XLEN-1:0] in2_q,        in2_d;
    logic [2:0]      funct3_q,     funct3_d;
    logic            funct7_q,     funct7_d;
    logic [XLEN-1:0] result_q,     result_d;

    logic            grant_valid;
    logic            grant_idx;
    logic            owner_rsp_ready;

    // Arbitration: single requester wins outright; on a tie the port that
    // did not win last time is granted. Ready is suppressed while in reset.
    always_comb begin
        grant_valid = rst_n && (state_q == IDLE) && (req0_valid || req1_valid);
        if (req0_valid && req1_valid) begin
            grant_idx = ~last_grant_q;
        end else begin
            grant_idx = req1_valid;
        end
    end

    assign req0_ready = grant_valid && !grant_idx;
    assign req1_ready = grant_valid &&  grant_idx;

    assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

    // Next-state and datapath register updates for the three-state sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        in1_d        = in1_q;
        in2_d        = in2_q;
        funct3_d     = funct3_q;
        funct7_d     = funct7_q;
        result_d     = result_q;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    in1_d        = grant_idx ? req1_in1    : req0_in1;
                    in2_d        = grant_idx ? req1_in2    : req0_in2;
                    funct3_d     = grant_idx ? req1_funct3 : req0_funct3;
                    funct7_d     = grant_idx ? req1_funct7 : req0_funct7;
                    owner_d      = grant_idx;
                    last_grant_d = grant_idx;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_out;
                state_d  = RESP;
            end
            RESP: begin
                if (owner_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: only control and small datapath registers live here, so all of
        // them are reset, which also forces every output to 0 during reset.
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            in1_q        <= '0;
            in2_q        <= '0;
            funct3_q     <= '0;
            funct7_q     <= 1'b0;
            result_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            in1_q        <= in1_d;
            in2_q        <= in2_d;
            funct3_q     <= funct3_d;
            funct7_q     <= funct7_d;
            result_q     <= result_d;
        end
    end

    assign alu_in1    = in1_q;
    assign alu_in2    = in2_q;
    assign alu_funct3 = funct3_q;
    assign alu_funct7 = funct7_q;

    assign rsp0_valid = (state_q == RESP) && !owner_q;
    assign rsp1_valid = (state_q == RESP) &&  owner_q;
    assign rsp0_data  = result_q;
    assign rsp1_data  = result_q;

    assign busy = (state_q != IDLE);

endmodule
